// File: rtl/div_arbiter.sv
// Two-requester front end for a shared iterative divider: round-robin grant,
// operand pre-check, watchdog timeout and a registered one-cycle response.
module div_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [9:0]  dvd0,
  input  logic [9:0]  dvd1,
  input  logic [4:0]  dvs0,
  input  logic [4:0]  dvs1,
  output logic        ack0,
  output logic        ack1,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [9:0]  rsp_q,
  output logic [4:0]  rsp_r,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic        div_start,
  output logic        div_gotResult,
  output logic [9:0]  div_dividend,
  output logic [4:0]  div_divisor,
  input  logic        div_done,
  input  logic [9:0]  div_Q,
  input  logic [10:0] div_A
);

  localparam int unsigned DW = 10;
  localparam int unsigned VW = 5;
  localparam int unsigned CW = 8;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, RESP} state_t;

  state_t          state, state_nxt;
  logic            grant, grant_nxt;
  logic            last_grant;
  logic [CW-1:0]   cnt;
  logic            any_req;
  logic            sel;
  logic [DW-1:0]   sel_dvd;
  logic [VW-1:0]   sel_dvs;
  logic [1:0]      pre_err;
  logic            timeout;

  // Upper remainder bits are never needed: the remainder is narrower than the divisor.
  logic unused_div_a;
  assign unused_div_a = ^div_A[10:5];

  // Arbitration, operand pre-check and next-state decode.
  always_comb begin
    any_req   = req0 | req1;
    sel       = (req0 && req1) ? ~last_grant : req1;
    sel_dvd   = sel ? dvd1 : dvd0;
    sel_dvs   = sel ? dvs1 : dvs0;
    if (sel_dvs == '0)
      pre_err = ERR_DIV0;
    else if (sel_dvd[DW-1 -: VW] >= sel_dvs)
      pre_err = ERR_OVF;
    else
      pre_err = ERR_OK;
    timeout   = (cnt == CW'(TIMEOUT - 1));
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = sel;
          state_nxt = (pre_err != ERR_OK) ? RESP : LAUNCH;
        end
      end
      LAUNCH:  state_nxt = WAIT;
      WAIT: begin
        if (div_done)
          state_nxt = CAPTURE;
        else if (timeout)
          state_nxt = RESP;
      end
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, watchdog, operand latch and registered outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= '0;
      busy          <= 1'b0;
      div_start     <= 1'b0;
      div_gotResult <= 1'b0;
      rsp_valid     <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_q         <= '0;
      rsp_r         <= '0;
      rsp_err       <= ERR_OK;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      busy          <= (state_nxt != IDLE);
      div_start     <= (state_nxt == LAUNCH);
      div_gotResult <= (state_nxt == CAPTURE);
      rsp_valid     <= (state_nxt == RESP);
      ack0          <= (state_nxt == RESP) && !grant_nxt;
      ack1          <= (state_nxt == RESP) && grant_nxt;

      if (state == IDLE && any_req) begin
        div_dividend <= sel_dvd;
        div_divisor  <= sel_dvs;
      end

      if (state == IDLE)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + CW'(1);

      if (state == RESP)
        last_grant <= grant;

      // Response fields change only on entry to RESP and hold until the next one.
      if (state_nxt == RESP) begin
        rsp_id <= grant_nxt;
        case (state)
          IDLE: begin
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_err <= pre_err;
          end
          CAPTURE: begin
            rsp_q   <= div_Q;
            rsp_r   <= div_A[VW-1:0];
            rsp_err <= ERR_OK;
          end
          default: begin
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_err <= ERR_TMO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: a default-TIMEOUT instance driven by a
// divider model, and a TIMEOUT=8 instance whose divider done is driven directly.
module tb_div_arbiter;

  typedef struct packed {
    logic       id;
    logic [9:0] q;
    logic [4:0] r;
    logic [1:0] err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic        req0, req1;
  logic [9:0]  dvd0, dvd1;
  logic [4:0]  dvs0, dvs1;
  logic        ack0, ack1, rsp_valid, rsp_id, busy, div_start, div_gotresult;
  logic [9:0]  rsp_q, div_dividend;
  logic [4:0]  rsp_r, div_divisor;
  logic [1:0]  rsp_err;
  logic        div_done;
  logic [9:0]  div_q;
  logic [10:0] div_a;

  // TIMEOUT=8 instance
  logic        t_req0;
  logic        t_req1 = 1'b0;
  logic [9:0]  t_dvd0;
  logic [9:0]  t_dvd1 = 10'd0;
  logic [4:0]  t_dvs0;
  logic [4:0]  t_dvs1 = 5'd0;
  logic        t_ack0, t_ack1, t_rsp_valid, t_rsp_id, t_busy, t_div_start, t_div_gotresult;
  logic [9:0]  t_rsp_q, t_div_dividend;
  logic [4:0]  t_rsp_r, t_div_divisor;
  logic [1:0]  t_rsp_err;
  logic        t_done;
  logic [9:0]  t_q;
  logic [10:0] t_a;

  div_arbiter u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .dvd0(dvd0), .dvd1(dvd1), .dvs0(dvs0), .dvs1(dvs1),
    .ack0(ack0), .ack1(ack1), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .busy(busy),
    .div_start(div_start), .div_gotResult(div_gotresult),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_Q(div_q), .div_A(div_a)
  );

  div_arbiter #(.TIMEOUT(8)) u_dut8 (
    .clk(clk), .rst(rst), .req0(t_req0), .req1(t_req1),
    .dvd0(t_dvd0), .dvd1(t_dvd1), .dvs0(t_dvs0), .dvs1(t_dvs1),
    .ack0(t_ack0), .ack1(t_ack1), .rsp_valid(t_rsp_valid), .rsp_id(t_rsp_id),
    .rsp_q(t_rsp_q), .rsp_r(t_rsp_r), .rsp_err(t_rsp_err), .busy(t_busy),
    .div_start(t_div_start), .div_gotResult(t_div_gotresult),
    .div_dividend(t_div_dividend), .div_divisor(t_div_divisor),
    .div_done(t_done), .div_Q(t_q), .div_A(t_a)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_start = 0;
  int   n_got   = 0;
  int   m_dly   = 12;
  int   m_cnt   = 0;
  logic m_run   = 1'b0;
  exp_t exp_q[$];
  exp_t exp8_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider model: answers m_dly cycles after start, holds done until result taken.
  always @(posedge clk) begin
    if (rst) begin
      div_done <= 1'b0;
      m_run    <= 1'b0;
      m_cnt    <= 0;
    end else if (div_start) begin
      m_run    <= 1'b1;
      m_cnt    <= m_dly;
      div_done <= 1'b0;
    end else if (m_run && !div_done) begin
      if (m_cnt <= 1) begin
        div_done <= 1'b1;
        div_q    <= 10'(div_dividend / 10'(div_divisor));
        div_a    <= 11'(div_dividend % 10'(div_divisor));
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (div_done && div_gotresult) begin
      div_done <= 1'b0;
      m_run    <= 1'b0;
    end
  end

  // Pulse counters for the main instance.
  always @(negedge clk) begin
    if (div_start)     n_start <= n_start + 1;
    if (div_gotresult) n_got   <= n_got + 1;
  end

  // Monitor: main instance responses against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_id",  32'(rsp_id),  32'(e.id));
        check("rsp_q",   32'(rsp_q),   32'(e.q));
        check("rsp_r",   32'(rsp_r),   32'(e.r));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("ack",     32'({ack1, ack0}), e.id ? 32'd2 : 32'd1);
      end
    end else if (ack0 || ack1) begin
      check("ack_without_rsp", 32'({ack1, ack0}), 0);
    end
  end

  // Monitor: TIMEOUT=8 instance responses against its scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (t_rsp_valid) begin
      check("t_rsp_expected", 32'(exp8_q.size() != 0), 1);
      if (exp8_q.size() != 0) begin
        e = exp8_q.pop_front();
        check("t_rsp_id",  32'(t_rsp_id),  32'(e.id));
        check("t_rsp_q",   32'(t_rsp_q),   32'(e.q));
        check("t_rsp_r",   32'(t_rsp_r),   32'(e.r));
        check("t_rsp_err", 32'(t_rsp_err), 32'(e.err));
        check("t_ack",     32'({t_ack1, t_ack0}), e.id ? 32'd2 : 32'd1);
      end
    end
  end

  // Counts negedges until the selected instance shows rsp_valid.
  task automatic wait_rsp(input bit which, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(which ? t_rsp_valid : rsp_valid) && lat < 200);
    check("rsp_wait", 32'(which ? t_rsp_valid : rsp_valid), 1);
  endtask

  task automatic wait_start(input bit which);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? t_div_start : div_start) && n < 50);
    check("start_wait", 32'(which ? t_div_start : div_start), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({busy, rsp_valid, ack0, ack1, div_start, div_gotresult}), 0);
    check({tag, "_rsp"}, 32'({rsp_id, rsp_q, rsp_r, rsp_err}), 0);
    check({tag, "_opd"}, 32'({div_dividend, div_divisor}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, g0, n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    dvd0 = '0; dvd1 = '0; dvs0 = '0; dvs1 = '0;
    t_req0 = 1'b0; t_dvd0 = 10'd100; t_dvs0 = 5'd7;
    t_done = 1'b0; t_q = '0; t_a = '0;
    div_q = '0; div_a = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("t_reset_busy", 32'(t_busy), 0);
    rst = 1'b0;

    // ok: 100 / 7 = 14 r 2
    @(posedge clk); #1;
    s0 = n_start; g0 = n_got;
    dvd0 = 10'd100; dvs0 = 5'd7; m_dly = 12;
    exp_q.push_back('{1'b0, 10'd14, 5'd2, 2'b00});
    req0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!div_done && n < 100);
    check("done_wait", 32'(div_done), 1);
    wait_rsp(1'b0, lat);
    check("ok_latency", 32'(lat), 2);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_q", 32'(rsp_q), 14);
    check("hold_r", 32'(rsp_r), 2);
    check("idle_busy", 32'(busy), 0);
    check("ok_starts", 32'(n_start - s0), 1);
    check("ok_gotresult", 32'(n_got - g0), 1);

    // errors on requester 1: divide by zero, then overflow
    @(posedge clk); #1;
    s0 = n_start;
    dvd1 = 10'd5; dvs1 = 5'd0;
    exp_q.push_back('{1'b1, 10'd0, 5'd0, 2'b01});
    req1 = 1'b1;
    wait_rsp(1'b0, lat);
    check("div0_latency", 32'(lat), 2);
    req1 = 1'b0;
    @(posedge clk); #1;
    dvd1 = 10'h3FF; dvs1 = 5'd3;
    exp_q.push_back('{1'b1, 10'd0, 5'd0, 2'b10});
    req1 = 1'b1;
    wait_rsp(1'b0, lat);
    check("ovf_latency", 32'(lat), 2);
    req1 = 1'b0;
    check("err_no_start", 32'(n_start - s0), 0);

    // fairness: both held high, grants alternate starting with 0
    @(posedge clk); #1;
    m_dly = 3;
    dvd0 = 10'd100; dvs0 = 5'd7;
    dvd1 = 10'd50;  dvs1 = 5'd9;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b0, 10'd14, 5'd2, 2'b00});
      exp_q.push_back('{1'b1, 10'd5,  5'd5, 2'b00});
    end
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) wait_rsp(1'b0, lat);
    req0 = 1'b0; req1 = 1'b0;

    // reset in WAIT: everything clears, no response, next request normal
    @(posedge clk); #1;
    m_dly = 12;
    req0 = 1'b1;
    wait_start(1'b0);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_idle", 32'(busy), 0);
    exp_q.push_back('{1'b0, 10'd14, 5'd2, 2'b00});
    req0 = 1'b1;
    wait_rsp(1'b0, lat);
    req0 = 1'b0;

    // timeout with TIMEOUT=8: 8 WAIT cycles after LAUNCH, then RESP
    exp8_q.push_back('{1'b0, 10'd0, 5'd0, 2'b11});
    t_req0 = 1'b1;
    wait_start(1'b1);
    check("t_latched_opd", 32'({t_div_dividend, t_div_divisor}), 32'({10'd100, 5'd7}));
    wait_rsp(1'b1, lat);
    check("timeout_negedges_after_launch", 32'(lat), 9);
    t_req0 = 1'b0;
    @(negedge clk);
    check("timeout_busy_falls", 32'(t_busy), 0);

    // done on the timeout cycle: capture wins
    t_q = 10'd14; t_a = 11'd2;
    exp8_q.push_back('{1'b0, 10'd14, 5'd2, 2'b00});
    t_req0 = 1'b1;
    wait_start(1'b1);
    repeat (8) @(negedge clk);
    t_done = 1'b1;
    n = 0; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (t_div_gotresult) begin n++; t_done = 1'b0; end
    end while (!t_rsp_valid && lat < 20);
    check("simul_latency", 32'(lat), 2);
    check("simul_gotresult", 32'(n), 1);
    t_req0 = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("t_scoreboard_drained", 32'(exp8_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
